// File: rtl/park_gate_ctrl.sv
// Parking-lot entry gate: password check, occupancy count and blinking status LEDs.
// Define PARK_LOCKOUT_EN to add the failed-attempt lockout (tries counter, LOCKED state, alarm).
module park_gate_ctrl #(
  parameter int unsigned      CAPACITY  = 8,
  parameter int unsigned      PW_W      = 4,
  parameter logic [PW_W-1:0]  PASSWORD  = 4'b0110,
  parameter int unsigned      WAIT_CYC  = 16,
  parameter int unsigned      MAX_TRIES = 3,
  parameter int unsigned      BLINK_DIV = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            sensor_entrance,
  input  logic            sensor_exit,
  input  logic            pw_valid,
  input  logic [PW_W-1:0] pw_data,
  input  logic            car_leave,
  input  logic            admin_unlock,
  output logic            green_led,
  output logic            red_led,
  output logic            gate_open,
  output logic            full,
  output logic [7:0]      count,
  output logic            alarm
);

  localparam int unsigned WaitW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam int unsigned DivW  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [2:0] {
    StIdle, StWaitPass, StWrongPass, StRightPass, StStop, StLocked
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       count_q, count_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [DivW-1:0]  div_q, div_d;
  logic             blink_q, blink_d;
  logic             exit_q;
  logic             pw_match, exit_rise, admit, fail;

`ifdef PARK_LOCKOUT_EN
  localparam int unsigned TryW = $clog2(MAX_TRIES + 1);
  logic [TryW-1:0] tries_q, tries_d;
`else
  logic unused_admin_unlock;
  assign unused_admin_unlock = admin_unlock;
`endif

  assign pw_match  = pw_valid && (pw_data == PASSWORD);
  assign exit_rise = sensor_exit && !exit_q;
  assign full      = (count_q == 8'(CAPACITY));

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    fail    = 1'b0;
    admit   = 1'b0;
    case (state_q)
      StIdle: if (sensor_entrance && !full) state_d = StWaitPass;
      StWaitPass: begin
        if (pw_match) state_d = StRightPass;
        else if (pw_valid || (wait_q == WaitW'(WAIT_CYC - 1))) fail = 1'b1;
        else wait_d = wait_q + WaitW'(1);
      end
      StWrongPass: begin
        if (pw_match) state_d = StRightPass;
        else if (pw_valid) fail = 1'b1;
        else if (!sensor_entrance) state_d = StIdle;
      end
      StRightPass: begin
        // Tailgate check wins over a simultaneous exit edge.
        if (sensor_entrance && sensor_exit) begin
          state_d = StStop;
        end else if (exit_rise && !sensor_entrance) begin
          admit   = 1'b1;
          state_d = StIdle;
        end
      end
      StStop: if (pw_match) state_d = StRightPass;
`ifdef PARK_LOCKOUT_EN
      StLocked: if (admin_unlock) state_d = StIdle;
`endif
      default: state_d = StIdle;
    endcase

`ifdef PARK_LOCKOUT_EN
    tries_d = tries_q;
    if (fail) begin
      tries_d = tries_q + TryW'(1);
      state_d = (tries_d == TryW'(MAX_TRIES)) ? StLocked : StWrongPass;
    end
    if (state_d == StIdle || state_d == StRightPass) tries_d = '0;
`else
    if (fail) state_d = StWrongPass;
`endif
  end

  always_comb begin
    count_d = count_q;
    if (admit && !car_leave) begin
      if (count_q < 8'(CAPACITY)) count_d = count_q + 8'd1;
    end else if (car_leave && !admit) begin
      if (count_q != 8'd0) count_d = count_q - 8'd1;
    end
  end

  // Blink phase restarts high whenever the state changes.
  always_comb begin
    blink_d = blink_q;
    div_d   = div_q;
    if (state_d != state_q) begin
      blink_d = 1'b1;
      div_d   = '0;
    end else if (div_q == DivW'(BLINK_DIV - 1)) begin
      blink_d = ~blink_q;
      div_d   = '0;
    end else begin
      div_d = div_q + DivW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      count_q <= '0;
      wait_q  <= '0;
      div_q   <= '0;
      blink_q <= 1'b0;
      exit_q  <= 1'b0;
`ifdef PARK_LOCKOUT_EN
      tries_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wait_q  <= wait_d;
      div_q   <= div_d;
      blink_q <= blink_d;
      exit_q  <= sensor_exit;
`ifdef PARK_LOCKOUT_EN
      tries_q <= tries_d;
`endif
    end
  end

  always_comb begin
    green_led = 1'b0;
    red_led   = 1'b0;
    case (state_q)
      StIdle:                        red_led   = full;
      StWaitPass:                    red_led   = 1'b1;
      StWrongPass, StStop, StLocked: red_led   = blink_q;
      StRightPass:                   green_led = blink_q;
      default:                       red_led   = 1'b0;
    endcase
  end

  assign gate_open = (state_q == StRightPass);
  assign count     = count_q;
`ifdef PARK_LOCKOUT_EN
  assign alarm = (state_q == StLocked);
`else
  assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_park_gate_ctrl.sv
// Scoreboard bench for park_gate_ctrl (CAPACITY=2); expectations adapt to PARK_LOCKOUT_EN.
module tb_park_gate_ctrl;

  typedef logic [12:0] exp_t;  // {green, red, gate, full, count[7:0], alarm}

`ifdef PARK_LOCKOUT_EN
  localparam logic LockEn = 1'b1;
`else
  localparam logic LockEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sensor_entrance, sensor_exit, pw_valid, car_leave, admin_unlock;
  logic [3:0] pw_data;
  logic       green_led, red_led, gate_open, full, alarm;
  logic [7:0] count;
  exp_t       obs;
  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  park_gate_ctrl #(.CAPACITY(2)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .sensor_entrance (sensor_entrance),
    .sensor_exit     (sensor_exit),
    .pw_valid        (pw_valid),
    .pw_data         (pw_data),
    .car_leave       (car_leave),
    .admin_unlock    (admin_unlock),
    .green_led       (green_led),
    .red_led         (red_led),
    .gate_open       (gate_open),
    .full            (full),
    .count           (count),
    .alarm           (alarm)
  );

  assign obs = {green_led, red_led, gate_open, full, count, alarm};

  function automatic exp_t e(input logic g, input logic r, input logic gt, input logic fl,
                             input int unsigned cnt, input logic al);
    return {g, r, gt, fl, 8'(cnt), al};
  endfunction

  task automatic check_eq(input string tag, input exp_t got, input exp_t want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got {g,r,gate,full,cnt,alarm}=%h required %h", tag, got, want);
    end
  endtask

  task automatic compare_next(input string tag);
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      check_eq(tag, obs, sb_q.pop_front());
    end
  endtask

  task automatic step(input string tag, input logic ent, input logic ex, input logic pv,
                      input logic [3:0] pd, input logic lv, input logic un, input exp_t want);
    sensor_entrance = ent;
    sensor_exit     = ex;
    pw_valid        = pv;
    pw_data         = pd;
    car_leave       = lv;
    admin_unlock    = un;
    sb_q.push_back(want);
    @(posedge clk);
    #1;
    compare_next(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    sensor_entrance = 1'b0;
    sensor_exit = 1'b0;
    pw_valid = 1'b0;
    pw_data = 4'h0;
    car_leave = 1'b0;
    admin_unlock = 1'b0;
    #2;
    sb_q.push_back(e(0, 0, 0, 0, 0, 0));
    compare_next("reset");
    #10 reset_n = 1'b1;

    // Normal entry: password on the third cycle, exit edge admits the car.
    step("ent_wait1", 1, 0, 0, 4'h0, 0, 0, e(0, 1, 0, 0, 0, 0));
    step("ent_wait2", 1, 0, 0, 4'h0, 0, 0, e(0, 1, 0, 0, 0, 0));
    step("ent_pw", 1, 0, 1, 4'b0110, 0, 0, e(1, 0, 1, 0, 0, 0));
    for (int i = 0; i < 4; i++) step("ent_green", 0, 0, 0, 4'h0, 0, 0, e(i < 3, 0, 1, 0, 0, 0));
    step("ent_exit", 0, 1, 0, 4'h0, 0, 0, e(0, 0, 0, 0, 1, 0));
    step("ent_idle", 0, 0, 0, 4'h0, 0, 0, e(0, 0, 0, 0, 1, 0));

    // Timeout after WAIT_CYC cycles, then red blinks with half-period 4.
    step("to_enter", 1, 0, 0, 4'h0, 0, 0, e(0, 1, 0, 0, 1, 0));
    for (int i = 0; i < 15; i++) step("to_wait", 1, 0, 0, 4'h0, 0, 0, e(0, 1, 0, 0, 1, 0));
    for (int i = 0; i < 9; i++)
      step("to_blink", 1, 0, 0, 4'h0, 0, 0, e(0, ((i / 4) % 2) == 0, 0, 0, 1, 0));
    step("to_pw", 1, 0, 1, 4'b0110, 0, 0, e(1, 0, 1, 0, 1, 0));
    step("to_exit", 0, 1, 0, 4'h0, 0, 0, e(0, 1, 0, 1, 2, 0));

    // Capacity: full blocks entry; leave and admit together cancel.
    for (int i = 0; i < 2; i++) step("cap_block", 1, 0, 0, 4'h0, 0, 0, e(0, 1, 0, 1, 2, 0));
    step("cap_leave", 0, 0, 0, 4'h0, 1, 0, e(0, 0, 0, 0, 1, 0));
    step("cap_wait", 1, 0, 0, 4'h0, 0, 0, e(0, 1, 0, 0, 1, 0));
    step("cap_pw", 1, 0, 1, 4'b0110, 0, 0, e(1, 0, 1, 0, 1, 0));
    step("cap_both", 0, 1, 0, 4'h0, 1, 0, e(0, 0, 0, 0, 1, 0));
    step("cap_leave2", 0, 0, 0, 4'h0, 1, 0, e(0, 0, 0, 0, 0, 0));
    step("cap_sat0", 0, 0, 0, 4'h0, 1, 0, e(0, 0, 0, 0, 0, 0));

    // Three wrong passwords: lockout when enabled, otherwise stays in WRONG_PASS.
    step("lk_wait", 1, 0, 0, 4'h0, 0, 0, e(0, 1, 0, 0, 0, 0));
    step("lk_bad1", 1, 0, 1, 4'b0000, 0, 0, e(0, 1, 0, 0, 0, 0));
    step("lk_bad2", 1, 0, 1, 4'b0000, 0, 0, e(0, 1, 0, 0, 0, 0));
    step("lk_bad3", 1, 0, 1, 4'b0000, 0, 0, e(0, 1, 0, 0, 0, LockEn));
    step("lk_bad4", 1, 0, 1, 4'b1111, 0, 0, e(0, 1, 0, 0, 0, LockEn));
`ifdef PARK_LOCKOUT_EN
    step("lk_ignore_pw", 1, 0, 1, 4'b0110, 0, 0, e(0, 1, 0, 0, 0, 1));
`endif
    step("lk_unlock", 0, 0, 0, 4'h0, 0, 1, e(0, 0, 0, 0, 0, 0));
    step("lk_rewait", 1, 0, 0, 4'h0, 0, 0, e(0, 1, 0, 0, 0, 0));
    step("lk_tries_clr", 1, 0, 1, 4'b0000, 0, 0, e(0, 1, 0, 0, 0, 0));
    step("lk_pw", 1, 0, 1, 4'b0110, 0, 0, e(1, 0, 1, 0, 0, 0));
    step("lk_exit", 0, 1, 0, 4'h0, 0, 0, e(0, 0, 0, 0, 1, 0));

    // Tailgate into STOP, recovery by password, then reset while in STOP.
    step("tg_wait", 1, 0, 0, 4'h0, 0, 0, e(0, 1, 0, 0, 1, 0));
    step("tg_pw", 1, 0, 1, 4'b0110, 0, 0, e(1, 0, 1, 0, 1, 0));
    step("tg_stop", 1, 1, 0, 4'h0, 0, 0, e(0, 1, 0, 0, 1, 0));
    step("tg_bad_pw", 0, 0, 1, 4'b0000, 0, 0, e(0, 1, 0, 0, 1, 0));
    step("tg_good_pw", 0, 0, 1, 4'b0110, 0, 0, e(1, 0, 1, 0, 1, 0));
    step("tg_stop2", 1, 1, 0, 4'h0, 0, 0, e(0, 1, 0, 0, 1, 0));
    step("tg_hold", 1, 1, 0, 4'h0, 0, 0, e(0, 1, 0, 0, 1, 0));
    reset_n = 1'b0;
    #1;
    sb_q.push_back(e(0, 0, 0, 0, 0, 0));
    compare_next("rst_mid_stop");
    #2 reset_n = 1'b1;
    step("rst_idle", 0, 0, 0, 4'h0, 0, 0, e(0, 0, 0, 0, 0, 0));
    step("rst_reenter", 1, 0, 0, 4'h0, 0, 0, e(0, 1, 0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
